// File: rtl/lcd_pkg.sv
// Shared types, init tables, default timing and the clear/home decoder for the LCD nibble controller.
package lcd_pkg;

   localparam int TIMER_W = 20;

   typedef enum logic [2:0] {
      PWR_WAIT  = 3'd0,
      INIT_NIB  = 3'd1,
      CMD_LOAD  = 3'd2,
      IDLE      = 3'd3,
      SETUP     = 3'd4,
      E_HIGH    = 3'd5,
      E_LOW_GAP = 3'd6,
      WAIT      = 3'd7
   } lcd_state_e;

   localparam logic [3:0] INIT_NIBBLES [0:3] = '{4'h3, 4'h3, 4'h3, 4'h2};
   localparam logic [7:0] INIT_CMDS    [0:3] = '{8'h28, 8'h06, 8'h0C, 8'h01};

   localparam int DEF_T_POWERON = 750000;
   localparam int DEF_T_INIT1   = 205000;
   localparam int DEF_T_INIT2   = 5000;
   localparam int DEF_T_CMD     = 2000;
   localparam int DEF_T_CLEAR   = 82000;
   localparam int DEF_T_AS      = 2;
   localparam int DEF_T_PW      = 12;
   localparam int DEF_T_NIB     = 50;

   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done_o is high for the single cycle the count sits at zero after a load or reset.
module lcd_delay_timer
   import lcd_pkg::*;
#(
   parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] value_i,
   output logic               done_o
);

   logic [TIMER_W-1:0] count_q;
   logic               armed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= RESET_VAL;
         armed_q <= 1'b1;
      end else if (load_i) begin
         count_q <= value_i;
         armed_q <= 1'b1;
      end else if (armed_q) begin
         if (count_q == '0) begin
            armed_q <= 1'b0;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign done_o = armed_q && (count_q == '0);

endmodule

// File: rtl/lcd_nibble_ctrl.sv
// Spartan-3E character LCD driver: power-on init, then byte writes as two timed nibbles.
// Define LCD_CMD_FIFO_EN to insert a 4-entry {rs,data} FIFO in front of the state machine.
module lcd_nibble_ctrl
   import lcd_pkg::*;
#(
   parameter int T_POWERON = DEF_T_POWERON,
   parameter int T_INIT1   = DEF_T_INIT1,
   parameter int T_INIT2   = DEF_T_INIT2,
   parameter int T_CMD     = DEF_T_CMD,
   parameter int T_CLEAR   = DEF_T_CLEAR,
   parameter int T_AS      = DEF_T_AS,
   parameter int T_PW      = DEF_T_PW,
   parameter int T_NIB     = DEF_T_NIB
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       init_done,
   output logic       sf_e,
   output logic       e,
   output logic       rs,
   output logic       rw,
   output logic       d,
   output logic       c,
   output logic       b,
   output logic       a
);

   // Timer reload values are duration-1 because the load cycle is the first cycle of the state
   localparam logic [TIMER_W-1:0] LD_AS  = TIMER_W'(T_AS - 1);
   localparam logic [TIMER_W-1:0] LD_PW  = TIMER_W'(T_PW - 1);
   localparam logic [TIMER_W-1:0] LD_NIB = TIMER_W'(T_NIB - 1);

   lcd_state_e         state_q, state_d;
   logic               rs_q, rs_d;
   logic [7:0]         byte_q, byte_d;
   logic [3:0]         nib_q, nib_d;
   logic               lowHalf_q, lowHalf_d;
   logic               single_q, single_d;
   logic [1:0]         idx_q, idx_d;
   logic               initDone_q, initDone_d;
   logic               timerLoad, timerDone;
   logic [TIMER_W-1:0] timerVal, waitCycles;
   logic               srcValid, srcRs, take;
   logic [7:0]         srcData;

   assign take = (state_q == IDLE) && initDone_q && srcValid;

`ifdef LCD_CMD_FIFO_EN
   logic [8:0] fifoMem_q [0:3];
   logic [1:0] wrPtr_q, rdPtr_q;
   logic [2:0] fifoCount_q;
   logic       push, fifoFull;

   assign fifoFull  = (fifoCount_q == 3'd4);
   assign cmd_ready = !fifoFull;
   assign push      = cmd_valid && !fifoFull;
   assign srcValid  = (fifoCount_q != 3'd0);
   assign {srcRs, srcData} = fifoMem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q     <= 2'd0;
         rdPtr_q     <= 2'd0;
         fifoCount_q <= 3'd0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 2'd1;
         if (take) rdPtr_q <= rdPtr_q + 2'd1;
         if (push && !take) begin
            fifoCount_q <= fifoCount_q + 3'd1;
         end else if (take && !push) begin
            fifoCount_q <= fifoCount_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifoMem_q[wrPtr_q] <= {cmd_rs, cmd_data};
   end
`else
   assign cmd_ready = (state_q == IDLE) && initDone_q;
   assign srcValid  = cmd_valid;
   assign srcRs     = cmd_rs;
   assign srcData   = cmd_data;
`endif

   always_comb begin
      waitCycles = TIMER_W'(T_CMD);
      if (single_q) begin
         case (idx_q)
            2'd0:    waitCycles = TIMER_W'(T_INIT1);
            2'd1:    waitCycles = TIMER_W'(T_INIT2);
            default: waitCycles = TIMER_W'(T_CMD);
         endcase
      end else if (is_long_cmd(rs_q, byte_q)) begin
         waitCycles = TIMER_W'(T_CLEAR);
      end
   end

   always_comb begin
      state_d    = state_q;
      rs_d       = rs_q;
      byte_d     = byte_q;
      nib_d      = nib_q;
      lowHalf_d  = lowHalf_q;
      single_d   = single_q;
      idx_d      = idx_q;
      initDone_d = initDone_q;
      timerLoad  = 1'b0;
      timerVal   = '0;
      case (state_q)
         PWR_WAIT: begin
            if (timerDone) begin
               idx_d   = 2'd0;
               state_d = INIT_NIB;
            end
         end
         INIT_NIB: begin
            rs_d      = 1'b0;
            nib_d     = INIT_NIBBLES[idx_q];
            single_d  = 1'b1;
            state_d   = SETUP;
            timerLoad = 1'b1;
            timerVal  = LD_AS;
         end
         CMD_LOAD: begin
            rs_d      = 1'b0;
            byte_d    = INIT_CMDS[idx_q];
            nib_d     = INIT_CMDS[idx_q][7:4];
            lowHalf_d = 1'b0;
            single_d  = 1'b0;
            state_d   = SETUP;
            timerLoad = 1'b1;
            timerVal  = LD_AS;
         end
         IDLE: begin
            if (take) begin
               rs_d      = srcRs;
               byte_d    = srcData;
               nib_d     = srcData[7:4];
               lowHalf_d = 1'b0;
               single_d  = 1'b0;
               state_d   = SETUP;
               timerLoad = 1'b1;
               timerVal  = LD_AS;
            end
         end
         SETUP: begin
            if (timerDone) begin
               state_d   = E_HIGH;
               timerLoad = 1'b1;
               timerVal  = LD_PW;
            end
         end
         E_HIGH: begin
            if (timerDone) begin
               state_d   = E_LOW_GAP;
               timerLoad = 1'b1;
               timerVal  = LD_NIB;
            end
         end
         E_LOW_GAP: begin
            if (timerDone) begin
               timerLoad = 1'b1;
               if (!single_q && !lowHalf_q) begin
                  lowHalf_d = 1'b1;
                  nib_d     = byte_q[3:0];
                  state_d   = SETUP;
                  timerVal  = LD_AS;
               end else begin
                  state_d   = WAIT;
                  timerVal  = waitCycles - 1'b1;
               end
            end
         end
         WAIT: begin
            // idx_q walks the nibble table first, then the byte table, before handing over to IDLE
            if (timerDone) begin
               if (single_q) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = (idx_q == 2'd3) ? CMD_LOAD : INIT_NIB;
               end else if (!initDone_q) begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     initDone_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     state_d = CMD_LOAD;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = PWR_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PWR_WAIT;
         rs_q       <= 1'b0;
         byte_q     <= 8'h00;
         nib_q      <= 4'h0;
         lowHalf_q  <= 1'b0;
         single_q   <= 1'b0;
         idx_q      <= 2'd0;
         initDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rs_d;
         byte_q     <= byte_d;
         nib_q      <= nib_d;
         lowHalf_q  <= lowHalf_d;
         single_q   <= single_d;
         idx_q      <= idx_d;
         initDone_q <= initDone_d;
      end
   end

   lcd_delay_timer #(
      .RESET_VAL(TIMER_W'(T_POWERON - 1))
   ) uTimer (
      .clk    (clk),
      .rst    (rst),
      .load_i (timerLoad),
      .value_i(timerVal),
      .done_o (timerDone)
   );

   assign e            = (state_q == E_HIGH);
   assign rs           = rs_q;
   assign rw           = 1'b0;
   assign sf_e         = 1'b1;
   assign {d, c, b, a} = nib_q;
   assign init_done    = initDone_q;

endmodule
